serial_fs_sub: RTL

- Bit-serial N-bit subtractor computing diff = a - b - bin, LSB first, one bit per clock.
- One full-subtractor cell plus a registered borrow flip-flop replaces the combinational ripple chain.
- Parallel operands are loaded on a start handshake; a parallel result and a done pulse come back WIDTH cycles later.
- Used where area matters more than latency; a software/bench checker compares it against a combinational full-subtractor chain.

---
 rtl/serial_fs_sub.sv | 128 ++++++++++++
 1 files changed

// File: rtl/serial_fs_sub.sv
// Bit-serial N-bit subtractor: one full-subtractor cell and a borrow flip-flop
// produce diff = a - b - bin LSB first, one bit per clock.
module serial_fs_sub #(
  parameter int WIDTH = 8,
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state_q;
  state_e           state_d;
  logic [CW-1:0]    count_q;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic             borrow_q;
  logic [WIDTH-1:0] diff_q;
  logic             bout_q;
  logic             ovf_q;
  logic             done_q;

  logic             accept;
  logic             shifting;
  logic             last;
  logic             x;
  logic             y;
  logic             c;
  logic             d;
  logic             bo;
  logic [WIDTH-1:0] res_next;

  assign accept   = (state_q == IDLE) && start;
  assign shifting = (state_q == SHIFT);
  assign last     = shifting && (count_q == LAST);

  // Full-subtractor cell fed by the operand LSBs and the stored borrow.
  assign x        = a_sr[0];
  assign y        = b_sr[0];
  assign c        = borrow_q;
  assign d        = x ^ y ^ c;
  assign bo       = (~x & y) | (~(x ^ y) & c);
  assign res_next = {d, res_sr[WIDTH-1:1]};

  // State register.
  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples the pre-edge value of its neighbours.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  // NOTE: state_d is given a default before the case so no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (start)           state_d = SHIFT;
      SHIFT: if (count_q == LAST) state_d = IDLE;
      default:                    state_d = IDLE;
    endcase
  end

  // Datapath: operand capture, serial shift and result commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q  <= '0;
      a_sr     <= '0;
      b_sr     <= '0;
      res_sr   <= '0;
      borrow_q <= 1'b0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        a_sr     <= a;
        b_sr     <= b;
        borrow_q <= bin;
        count_q  <= '0;
      end else if (shifting) begin
        a_sr     <= a_sr >> 1;
        b_sr     <= b_sr >> 1;
        res_sr   <= res_next;
        borrow_q <= bo;
        count_q  <= count_q + CW'(1);
        if (last) begin
          // On the MSB step borrow_q is the borrow into the MSB.
          diff_q <= res_next;
          bout_q <= bo;
          ovf_q  <= borrow_q ^ bo;
          done_q <= 1'b1;
        end
      end
    end
  end

  // Output logic.
  always_comb begin
    busy = shifting;
    done = done_q;
    diff = diff_q;
    bout = bout_q;
    ovf  = ovf_q;
  end

endmodule
